// File: rtl/core_dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : core_dmem_if
// Purpose  : Core-side data-memory interface. Turns a single-cycle load or
//            store start into one bus transaction (REQ held until ACK or
//            timeout), lane-aligns store data, extracts and sign/zero-extends
//            load data by byte strobe, and reports completion or fault.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT     max REQ-state cycles without DMEM_ACK before fault (1..65535)
// Ports
//   CLK         in   1   clock, rising edge
//   NRST        in   1   asynchronous active-low reset
//   ISLOAD_SS   in   1   single-cycle load start
//   ISSTORE_SS  in   1   single-cycle store start (wins over load)
//   ISLOADBS    in   1   signed-byte load
//   ISLOADHWS   in   1   signed-halfword load
//   STRB        in   4   byte-lane strobe
//   ADDR        in  32   byte address
//   STORE_DATA  in  32   store data, LSB-justified
//   DMEM_REQ    out  1   bus request
//   DMEM_WE     out  1   bus write enable
//   DMEM_ADDR   out 32   word-aligned bus address
//   DMEM_WDATA  out 32   lane-aligned write data
//   DMEM_WSTRB  out  4   bus byte enables
//   DMEM_ACK    in   1   bus completion
//   DMEM_RDATA  in  32   bus read data, valid with ACK
//   BUSY        out  1   transaction in flight
//   LOAD_DATA   out 32   extended load result (held between loads)
//   LOAD_VALID  out  1   one-cycle load-complete pulse
//   STORE_DONE  out  1   one-cycle store-complete pulse
//   FAULT       out  1   one-cycle error pulse
// ============================================================================
module core_dmem_if #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        NRST,
   input  logic        ISLOAD_SS,
   input  logic        ISSTORE_SS,
   input  logic        ISLOADBS,
   input  logic        ISLOADHWS,
   input  logic [3:0]  STRB,
   input  logic [31:0] ADDR,
   input  logic [31:0] STORE_DATA,
   output logic        DMEM_REQ,
   output logic        DMEM_WE,
   output logic [31:0] DMEM_ADDR,
   output logic [31:0] DMEM_WDATA,
   output logic [3:0]  DMEM_WSTRB,
   input  logic        DMEM_ACK,
   input  logic [31:0] DMEM_RDATA,
   output logic        BUSY,
   output logic [31:0] LOAD_DATA,
   output logic        LOAD_VALID,
   output logic        STORE_DONE,
   output logic        FAULT
);

   localparam logic [1:0]  c_IDLE    = 2'd0;
   localparam logic [1:0]  c_REQ     = 2'd1;
   localparam logic [1:0]  c_DONE    = 2'd2;
   localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic        r_busy;
   logic [29:0] r_addr_word;
   logic [3:0]  r_strb;
   logic [31:0] r_wdata;
   logic        r_is_store;
   logic        r_sx_byte;
   logic        r_sx_half;
   logic [15:0] r_cnt;
   logic        r_fault;
   logic [31:0] r_load_data;

   logic        w_start;
   logic        w_timeout;
   logic [31:0] w_ext;
   logic        w_ext_bad;

   assign w_start   = ISLOAD_SS | ISSTORE_SS;
   assign w_timeout = (r_cnt == c_TO_LAST);

   // ------------------------------------------------------------------------
   // State register. BUSY is registered alongside the state so it is a clean
   // flop output that equals (state != IDLE).
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_state <= c_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != c_IDLE);
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. A zero strobe has no lanes to move, so it bypasses the
   // bus and goes straight to DONE with a fault. ACK beats the timeout.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_start) begin
               w_next = (STRB == 4'b0000) ? c_DONE : c_REQ;
            end
         end
         c_REQ: begin
            if (DMEM_ACK || w_timeout) begin
               w_next = c_DONE;
            end
         end
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic. Bus-side signals are only non-zero while in REQ, which
   // also makes them drop the instant reset forces the state to IDLE.
   // ------------------------------------------------------------------------
   always_comb begin
      DMEM_REQ   = 1'b0;
      DMEM_WE    = 1'b0;
      DMEM_ADDR  = 32'h0;
      DMEM_WDATA = 32'h0;
      DMEM_WSTRB = 4'h0;
      LOAD_VALID = 1'b0;
      STORE_DONE = 1'b0;
      FAULT      = 1'b0;
      case (r_state)
         c_REQ: begin
            DMEM_REQ   = 1'b1;
            DMEM_WE    = r_is_store;
            DMEM_ADDR  = {r_addr_word, 2'b00};
            DMEM_WDATA = r_wdata;
            DMEM_WSTRB = r_strb;
         end
         c_DONE: begin
            LOAD_VALID = ~r_is_store;
            STORE_DONE = r_is_store;
            FAULT      = r_fault;
         end
         default: ;
      endcase
   end

   assign BUSY      = r_busy;
   assign LOAD_DATA = r_load_data;

   // ------------------------------------------------------------------------
   // Load extraction from the bus read data, selected by the captured strobe.
   // Strobe patterns that are not a naturally aligned byte, halfword or word
   // are flagged as bad.
   // ------------------------------------------------------------------------
   always_comb begin
      w_ext     = 32'h0;
      w_ext_bad = 1'b0;
      case (r_strb)
         4'b0001: w_ext = {{24{r_sx_byte & DMEM_RDATA[7]}},  DMEM_RDATA[7:0]};
         4'b0010: w_ext = {{24{r_sx_byte & DMEM_RDATA[15]}}, DMEM_RDATA[15:8]};
         4'b0100: w_ext = {{24{r_sx_byte & DMEM_RDATA[23]}}, DMEM_RDATA[23:16]};
         4'b1000: w_ext = {{24{r_sx_byte & DMEM_RDATA[31]}}, DMEM_RDATA[31:24]};
         4'b0011: w_ext = {{16{r_sx_half & DMEM_RDATA[15]}}, DMEM_RDATA[15:0]};
         4'b1100: w_ext = {{16{r_sx_half & DMEM_RDATA[31]}}, DMEM_RDATA[31:16]};
         4'b1111: w_ext = DMEM_RDATA;
         default: w_ext_bad = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // Transaction datapath: request capture, timeout counter, fault flag and
   // the load result register.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_addr_word <= 30'h0;
         r_strb      <= 4'h0;
         r_wdata     <= 32'h0;
         r_is_store  <= 1'b0;
         r_sx_byte   <= 1'b0;
         r_sx_half   <= 1'b0;
         r_cnt       <= 16'h0;
         r_fault     <= 1'b0;
         r_load_data <= 32'h0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_cnt <= 16'h0;
               if (w_start) begin
                  r_addr_word <= ADDR[31:2];
                  r_strb      <= STRB;
                  // Shift into the addressed lane; bytes past bit 31 drop off.
                  r_wdata     <= STORE_DATA << {ADDR[1:0], 3'b000};
                  r_is_store  <= ISSTORE_SS;
                  r_sx_byte   <= ISLOADBS;
                  r_sx_half   <= ISLOADHWS;
                  r_fault     <= (STRB == 4'b0000);
                  if ((STRB == 4'b0000) && !ISSTORE_SS) begin
                     r_load_data <= 32'h0;
                  end
               end
            end
            c_REQ: begin
               if (DMEM_ACK) begin
                  r_fault <= ~r_is_store & w_ext_bad;
                  if (!r_is_store) begin
                     r_load_data <= w_ext;
                  end
               end else if (w_timeout) begin
                  r_fault <= 1'b1;
                  if (!r_is_store) begin
                     r_load_data <= 32'h0;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'h1;
               end
            end
            default: r_cnt <= 16'h0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_dmem_if
// Purpose  : Directed bench for core_dmem_if (TIMEOUT = 4). Expected
//            completions are queued when a start is driven and popped by a
//            monitor when the DUT pulses LOAD_VALID / STORE_DONE / FAULT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_dmem_if;

   logic        CLK = 1'b0;
   logic        NRST;
   logic        ISLOAD_SS, ISSTORE_SS, ISLOADBS, ISLOADHWS;
   logic [3:0]  STRB;
   logic [31:0] ADDR, STORE_DATA;
   logic        DMEM_REQ, DMEM_WE;
   logic [31:0] DMEM_ADDR, DMEM_WDATA;
   logic [3:0]  DMEM_WSTRB;
   logic        DMEM_ACK;
   logic [31:0] DMEM_RDATA;
   logic        BUSY;
   logic [31:0] LOAD_DATA;
   logic        LOAD_VALID, STORE_DONE, FAULT;

   core_dmem_if #(.TIMEOUT(4)) dut (
      .CLK(CLK), .NRST(NRST),
      .ISLOAD_SS(ISLOAD_SS), .ISSTORE_SS(ISSTORE_SS),
      .ISLOADBS(ISLOADBS), .ISLOADHWS(ISLOADHWS),
      .STRB(STRB), .ADDR(ADDR), .STORE_DATA(STORE_DATA),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB),
      .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
      .BUSY(BUSY), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID),
      .STORE_DONE(STORE_DONE), .FAULT(FAULT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_store;
      logic [31:0] data;
      bit          fault;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [31:0] last_load = 32'h0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Completion monitor: every pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (LOAD_VALID || STORE_DONE || FAULT) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {29'h0, LOAD_VALID, STORE_DONE, FAULT}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mon_load_valid", {31'h0, LOAD_VALID}, {31'h0, ~e.is_store});
            chk("mon_store_done", {31'h0, STORE_DONE}, {31'h0, e.is_store});
            chk("mon_fault",      {31'h0, FAULT},      {31'h0, e.fault});
            chk("mon_load_data",  LOAD_DATA,           e.data);
            chk("mon_done_cycle", cyc,                 e.cyc);
         end
      end
   end

   // Full bus transaction. Called at a negedge in IDLE; returns at the
   // negedge after DONE (IDLE again).
   task automatic txn(input bit st, input bit ld, input bit bs, input bit hws,
                      input logic [3:0] strb, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic [31:0] rdata,
                      input int delay, input logic [31:0] exp_wdata,
                      input logic [31:0] exp_ld, input bit exp_fault, input bit spur);
      exp_t e;
      ISLOAD_SS = ld; ISSTORE_SS = st; ISLOADBS = bs; ISLOADHWS = hws;
      STRB = strb; ADDR = addr; STORE_DATA = sdata;
      e.is_store = st; e.fault = exp_fault; e.cyc = cyc + 2 + delay;
      if (st) e.data = last_load;
      else begin e.data = exp_ld; last_load = exp_ld; end
      sb.push_back(e);
      @(negedge CLK);
      // Scramble inputs to prove the request was captured.
      ISLOAD_SS = 1'b0; ISSTORE_SS = 1'b0;
      ISLOADBS = 1'($urandom); ISLOADHWS = 1'($urandom);
      ADDR = $urandom; STRB = 4'($urandom); STORE_DATA = $urandom;
      chk("req_high", {31'h0, DMEM_REQ}, 32'h1);
      chk("req_busy", {31'h0, BUSY}, 32'h1);
      chk("req_addr", DMEM_ADDR, {addr[31:2], 2'b00});
      chk("req_we", {31'h0, DMEM_WE}, {31'h0, st});
      chk("req_wstrb", {28'h0, DMEM_WSTRB}, {28'h0, strb});
      if (st) chk("req_wdata", DMEM_WDATA, exp_wdata);
      for (int i = 0; i < delay; i++) begin
         if (spur && i == 0) begin
            ISLOAD_SS = 1'b1; ISSTORE_SS = 1'b1; STRB = 4'hF; ADDR = 32'hFFFF_FFF0;
         end
         DMEM_RDATA = $urandom;
         @(negedge CLK);
         ISLOAD_SS = 1'b0; ISSTORE_SS = 1'b0;
         chk("hold_req", {31'h0, DMEM_REQ}, 32'h1);
         chk("hold_addr", DMEM_ADDR, {addr[31:2], 2'b00});
         chk("hold_wstrb", {28'h0, DMEM_WSTRB}, {28'h0, strb});
      end
      DMEM_ACK = 1'b1; DMEM_RDATA = rdata;
      @(negedge CLK);
      DMEM_ACK = 1'b0; DMEM_RDATA = $urandom;
      chk("done_req_low", {31'h0, DMEM_REQ}, 32'h0);
      chk("done_busy", {31'h0, BUSY}, 32'h1);
      @(negedge CLK);
      chk("idle_busy", {31'h0, BUSY}, 32'h0);
      chk("sb_drained", sb.size(), 32'h0);
   endtask

   // Zero-strobe start: no bus request, DONE on the following cycle.
   task automatic zero_strb(input bit st);
      exp_t e;
      ISLOAD_SS = ~st; ISSTORE_SS = st; STRB = 4'h0; ADDR = 32'h6000;
      e.is_store = st; e.fault = 1'b1; e.cyc = cyc + 1;
      if (st) e.data = last_load;
      else begin e.data = 32'h0; last_load = 32'h0; end
      sb.push_back(e);
      @(negedge CLK);
      ISLOAD_SS = 1'b0; ISSTORE_SS = 1'b0;
      chk("z_no_req", {31'h0, DMEM_REQ}, 32'h0);
      chk("z_busy", {31'h0, BUSY}, 32'h1);
      @(negedge CLK);
      chk("z_idle", {31'h0, BUSY}, 32'h0);
      chk("z_sb_drained", sb.size(), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_req;
      NRST = 1'b0; ISLOAD_SS = 0; ISSTORE_SS = 0; ISLOADBS = 0; ISLOADHWS = 0;
      STRB = 0; ADDR = 0; STORE_DATA = 0; DMEM_ACK = 0; DMEM_RDATA = 0;
      repeat (2) @(negedge CLK);
      chk("rst_req", {31'h0, DMEM_REQ}, 32'h0);
      chk("rst_busy", {31'h0, BUSY}, 32'h0);
      chk("rst_addr", DMEM_ADDR, 32'h0);
      chk("rst_wdata", DMEM_WDATA, 32'h0);
      chk("rst_load_data", LOAD_DATA, 32'h0);
      chk("rst_pulses", {29'h0, LOAD_VALID, STORE_DONE, FAULT}, 32'h0);
      NRST = 1'b1;

      // LB signed, top byte, ACK in first REQ cycle (start accepted at once)
      txn(0, 1, 1, 0, 4'b1000, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 32'h0, 32'hFFFF_FF80, 0, 0);
      // LHU upper half, ACK on the last allowed cycle, stray starts in REQ
      txn(0, 1, 0, 0, 4'b1100, 32'h1002, 32'h0, 32'hBEEF_1234, 3, 32'h0, 32'h0000_BEEF, 0, 1);
      // LH signed lower half
      txn(0, 1, 0, 1, 4'b0011, 32'h1000, 32'h0, 32'h1234_8001, 0, 32'h0, 32'hFFFF_8001, 0, 0);
      // LBU byte 1, zero-extended
      txn(0, 1, 0, 0, 4'b0010, 32'h1001, 32'h0, 32'h0000_9A00, 0, 32'h0, 32'h0000_009A, 0, 0);
      // LW
      txn(0, 1, 0, 0, 4'b1111, 32'h1004, 32'h0, 32'hDEAD_BEEF, 1, 32'h0, 32'hDEAD_BEEF, 0, 0);

      // Reset during REQ
      ISLOAD_SS = 1'b1; STRB = 4'hF; ADDR = 32'h3000;
      @(negedge CLK);
      ISLOAD_SS = 1'b0;
      chk("mid_req_high", {31'h0, DMEM_REQ}, 32'h1);
      NRST = 1'b0;
      #1;
      chk("mid_rst_req", {31'h0, DMEM_REQ}, 32'h0);
      chk("mid_rst_busy", {31'h0, BUSY}, 32'h0);
      chk("mid_rst_addr", DMEM_ADDR, 32'h0);
      chk("mid_rst_load_data", LOAD_DATA, 32'h0);
      last_load = 32'h0;
      @(negedge CLK);
      NRST = 1'b1;
      txn(0, 1, 0, 0, 4'b1111, 32'h3000, 32'h0, 32'h0BAD_F00D, 0, 32'h0, 32'h0BAD_F00D, 0, 0);

      // SH to an odd address: data shifted one lane
      txn(1, 0, 0, 0, 4'b0110, 32'h2001, 32'h0000_ABCD, 32'h0, 0, 32'h00AB_CD00, 32'h0, 0, 0);
      // Shift past bit 31 truncates
      txn(1, 0, 0, 0, 4'b1000, 32'h2003, 32'h1234_56A5, 32'h0, 2, 32'hA500_0000, 32'h0, 0, 0);
      // Both starts: store wins
      txn(1, 1, 0, 0, 4'b1111, 32'h4000, 32'h1122_3344, 32'h0, 0, 32'h1122_3344, 32'h0, 0, 0);
      // Illegal load strobe: bus cycle runs, result zero, fault
      txn(0, 1, 1, 1, 4'b0101, 32'h5000, 32'h0, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 1, 0);
      // Zero strobe, store then load
      txn(0, 1, 0, 0, 4'b1111, 32'h1008, 32'h0, 32'hCAFE_0001, 0, 32'h0, 32'hCAFE_0001, 0, 0);
      zero_strb(1'b1);
      zero_strb(1'b0);

      // ACK in IDLE is ignored
      txn(0, 1, 0, 0, 4'b0100, 32'h100A, 32'h0, 32'h0077_0000, 0, 32'h0, 32'h0000_0077, 0, 0);
      DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("idle_ack_busy", {31'h0, BUSY}, 32'h0);
         chk("idle_ack_load_data", LOAD_DATA, last_load);
      end
      DMEM_ACK = 1'b0;

      // Timeout: load with no ACK, REQ high for exactly TIMEOUT cycles
      begin
         exp_t e;
         ISLOAD_SS = 1'b1; STRB = 4'hF; ADDR = 32'h7000;
         e.is_store = 1'b0; e.data = 32'h0; e.fault = 1'b1; e.cyc = cyc + 5;
         sb.push_back(e); last_load = 32'h0;
         @(negedge CLK);
         ISLOAD_SS = 1'b0;
         n_req = 0;
         for (int i = 0; i < 12; i++) begin
            if (!BUSY) break;
            if (DMEM_REQ) n_req++;
            @(negedge CLK);
         end
         chk("to_req_cycles", n_req, 32'd4);
         chk("to_idle", {31'h0, BUSY}, 32'h0);
         chk("to_sb_drained", sb.size(), 32'h0);
      end

      // Back-to-back normal access after a timeout
      txn(0, 1, 1, 0, 4'b0001, 32'h1010, 32'h0, 32'h0000_007F, 2, 32'h0, 32'h0000_007F, 0, 0);

      repeat (2) @(negedge CLK);
      chk("final_sb_empty", sb.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_dmem_if.md
CORE_DMEM_IF -- requirements
Module: core_dmem_if

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, 255, max REQ-state cycles without DMEM_ACK before fault (range 1..65535).
REQ-002 The block SHALL have these ports:
- CLK  in  1  clock, rising edge.
- NRST  in  1  reset, active-low, asynchronous.
- ISLOAD_SS  in  1  single-cycle load start.
- ISSTORE_SS  in  1  single-cycle store start.
- ISLOADBS  in  1  signed-byte load.
- ISLOADHWS  in  1  signed-halfword load.
- STRB  in  4  byte-lane strobe.
- ADDR  in  32  byte address.
- STORE_DATA  in  32  store data, unaligned, LSB-justified.
- DMEM_REQ  out  1  bus request.
- DMEM_WE  out  1  bus write enable.
- DMEM_ADDR  out  32  word-aligned bus address.
- DMEM_WDATA  out  32  lane-aligned write data.
- DMEM_WSTRB  out  4  bus byte enables.
- DMEM_ACK  in  1  bus completion.
- DMEM_RDATA  in  32  bus read data, valid with ACK.
- BUSY  out  1  transaction in flight.
- LOAD_DATA  out  32  extended load result.
- LOAD_VALID  out  1  one-cycle load-complete pulse.
- STORE_DONE  out  1  one-cycle store-complete pulse.
- FAULT  out  1  one-cycle error pulse.
REQ-003 Clock is CLK; reset is NRST, asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, REQ, DONE; BUSY = (state != IDLE), registered.
REQ-005 In IDLE, a start (ISLOAD_SS or ISSTORE_SS) SHALL capture ADDR, STRB, STORE_DATA, ISLOADBS, ISLOADHWS and op type, and move to REQ on the next edge.
- Both starts high: store wins, load dropped.
- Starts outside IDLE: ignored.
REQ-006 STRB==0 at start SHALL skip REQ: next state DONE, FAULT=1, no bus request.
REQ-007 In REQ the block SHALL drive:
- DMEM_REQ=1.
- DMEM_ADDR={ADDR[31:2],2'b00}.
- DMEM_WSTRB=captured STRB.
- DMEM_WE=1 for stores, 0 for loads.
- DMEM_WDATA=STORE_DATA<<(8*ADDR[1:0]), upper bits truncated.
All of these are held stable until ACK.
REQ-008 DMEM_ACK sampled high in REQ SHALL move to DONE; for loads DMEM_RDATA is captured on that edge. ACK is allowed in the first REQ cycle.
REQ-009 Timeout counter: 16 bits, cleared on entering REQ, +1 per REQ cycle without ACK. Count==TIMEOUT-1 with no ACK SHALL move to DONE with FAULT=1, load result 0. ACK on that same cycle wins: no fault.
REQ-010 DONE SHALL last exactly one cycle, then IDLE. DMEM_REQ=0 in DONE.
- Loads: LOAD_VALID=1.
- Stores: STORE_DONE=1.
- FAULT=1 if flagged.
REQ-011 Load extraction from captured RDATA by STRB:
- 0001/0010/0100/1000 → byte 0/1/2/3, sign-extended if ISLOADBS else zero-extended.
- 0011 → bits[15:0]; 1100 → bits[31:16]; sign-extended if ISLOADHWS else zero-extended.
- 1111 → full word.
- Any other nonzero STRB → LOAD_DATA=0 and FAULT=1 in DONE.
REQ-012 LOAD_DATA SHALL update only on load completion and hold between loads.
REQ-013 Minimum latency: start at cycle N, REQ at N+1, DONE at N+2, IDLE at N+3. Each cycle ACK is withheld adds one cycle.
REQ-014 DMEM_ACK outside REQ SHALL be ignored.

Reset
REQ-015 NRST low SHALL immediately force the following, even mid-transaction:
- state IDLE, counter 0.
- DMEM_REQ, DMEM_WE, BUSY, LOAD_VALID, STORE_DONE, FAULT = 0.
- DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB, LOAD_DATA = 0.
REQ-016 After NRST deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-017 Directed scenarios:
- LB: ADDR=0x1003, STRB=1000, ISLOADBS=1, RDATA=0x80FFFFFF, ACK first REQ cycle → DMEM_ADDR=0x1000, LOAD_VALID at N+2, LOAD_DATA=0xFFFFFF80.
- LHU: STRB=1100, ISLOADHWS=0, RDATA=0xBEEF1234, ACK delayed 3 cycles → LOAD_DATA=0x0000BEEF, LOAD_VALID at N+5.
- SH: ADDR=0x2001, STRB=0110, STORE_DATA=0x0000ABCD → DMEM_WE=1, DMEM_WDATA=0x00ABCD00, DMEM_WSTRB=0110, STORE_DONE one cycle after ACK.
- Timeout: TIMEOUT=4, load, no ACK → DMEM_REQ high exactly 4 cycles, then DONE with FAULT=1, LOAD_VALID=1, LOAD_DATA=0.
- Both starts high, STRB=1111 → bus write only, STORE_DONE=1, LOAD_VALID stays 0.
- NRST low in REQ → DMEM_REQ and BUSY drop before the next edge; a start after release gives DMEM_REQ=1 one cycle later.
